// File: rtl/pe_dual_port_ram_if.sv
// ----------------------------------------------------------------------------
// pe_dual_port_ram_if
//
// Bus bundle for the processing-element local data RAM. It groups both access
// ports into one interface:
//   port A (DMA engine):  a_enable_in, a_addr_in, a_data_in, a_wb_in -> a_data_out
//   port B (CPU path):    b_enable_in, b_addr_in, b_data_in, b_wb_in -> b_data_out
//
// Handshake: there is no valid/ready pair. An access is requested by holding
// *_enable_in high across a rising clock edge. The RAM always accepts it in
// that cycle and never stalls. Read data is registered and appears on
// *_data_out after that edge. It stays there until the next enabled edge.
//
// Modports:
//   master - requester side (drives enables, addresses, write data, lanes)
//   slave  - RAM side (drives the registered read data)
// ----------------------------------------------------------------------------
interface pe_dual_port_ram_if #(
    parameter int WIDTH = 32
);
    logic             a_enable_in;
    logic [WIDTH-1:0] a_addr_in;
    logic [WIDTH-1:0] a_data_in;
    logic [3:0]       a_wb_in;
    logic [WIDTH-1:0] a_data_out;

    logic             b_enable_in;
    logic [WIDTH-1:0] b_addr_in;
    logic [WIDTH-1:0] b_data_in;
    logic [3:0]       b_wb_in;
    logic [WIDTH-1:0] b_data_out;

    modport master (
        output a_enable_in, a_addr_in, a_data_in, a_wb_in,
        output b_enable_in, b_addr_in, b_data_in, b_wb_in,
        input  a_data_out, b_data_out
    );

    modport slave (
        input  a_enable_in, a_addr_in, a_data_in, a_wb_in,
        input  b_enable_in, b_addr_in, b_data_in, b_wb_in,
        output a_data_out, b_data_out
    );
endinterface

// File: rtl/pe_dual_port_ram.sv
// ----------------------------------------------------------------------------
// pe_dual_port_ram
//
// Word-organised true dual-port synchronous RAM. It is the local data memory
// of one manycore processing element. Port A serves the DMA engine and port B
// serves the CPU path. Each port has byte-lane write enables and a one-cycle
// registered read that returns the old word (read-first).
//
// Ports:
//   clock  - single clock; every state update happens on its rising edge
//   reset  - asynchronous, active-high; clears only the read-data registers
//   bus    - pe_dual_port_ram_if.slave carrying both access ports
//
// Parameters:
//   MEMORY_WIDTH - data/address width; only 32 is supported
//   RAM_MSIZE    - size in bytes; power of two, multiple of 4
//   ADDRESS      - node address of the owning PE; used only in the warning
// ----------------------------------------------------------------------------
module pe_dual_port_ram #(
    parameter int MEMORY_WIDTH = 32,
    parameter int RAM_MSIZE    = 65536,
    parameter int ADDRESS      = 0
) (
    input logic              clock,
    input logic              reset,
    pe_dual_port_ram_if.slave bus
);
    localparam int DEPTH = RAM_MSIZE / 4;
    localparam int IDX_W = $clog2(DEPTH);

    if (MEMORY_WIDTH != 32 || (RAM_MSIZE & (RAM_MSIZE - 1)) != 0) begin : g_param_warn
        $warning("pe_dual_port_ram @ node %0d: unsupported MEMORY_WIDTH=%0d / RAM_MSIZE=%0d",
                 ADDRESS, MEMORY_WIDTH, RAM_MSIZE);
    end

    // Zero contents at time 0. The array has no reset, so it can map onto
    // block RAM.
    logic [MEMORY_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // Masking with RAM_MSIZE-1 and dropping bits [1:0] is the same as
    // slicing the word-index bits. Upper bits give modulo wrap-around.
    logic [IDX_W-1:0] a_idx;
    logic [IDX_W-1:0] b_idx;

    assign a_idx = bus.a_addr_in[IDX_W+1:2];
    assign b_idx = bus.b_addr_in[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.a_addr_in[MEMORY_WIDTH-1:IDX_W+2], bus.a_addr_in[1:0],
                                bus.b_addr_in[MEMORY_WIDTH-1:IDX_W+2], bus.b_addr_in[1:0]};

    // Both ports write through one process. Port A's assignments come last,
    // so on a lane written by both ports in the same cycle port A's byte wins.
    always_ff @(posedge clock) begin
        if (bus.b_enable_in) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.b_wb_in[i]) begin
                    mem[b_idx][8*i +: 8] <= bus.b_data_in[8*i +: 8];
                end
            end
        end
        if (bus.a_enable_in) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.a_wb_in[i]) begin
                    mem[a_idx][8*i +: 8] <= bus.a_data_in[8*i +: 8];
                end
            end
        end
    end

    // Read registers sample the pre-edge array contents. This gives
    // read-first behaviour on both the same port and the other port, and it
    // adds no combinational path from the inputs to the outputs.
    logic [MEMORY_WIDTH-1:0] a_q;
    logic [MEMORY_WIDTH-1:0] b_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q <= '0;
        end else if (bus.a_enable_in) begin
            a_q <= mem[a_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_q <= '0;
        end else if (bus.b_enable_in) begin
            b_q <= mem[b_idx];
        end
    end

    assign bus.a_data_out = a_q;
    assign bus.b_data_out = b_q;
endmodule

// File: tb/tb_pe_dual_port_ram.sv
module tb_pe_dual_port_ram;
    // ------------------------------------------------------------ clock/reset
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    pe_dual_port_ram_if #(.WIDTH(32)) bus ();

    pe_dual_port_ram #(
        .MEMORY_WIDTH(32),
        .RAM_MSIZE(65536),
        .ADDRESS(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // ------------------------------------------------------------ scoreboard
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        string       name;
        logic        a_en;
        logic [31:0] a_addr;
        logic [31:0] a_data;
        logic [3:0]  a_wb;
        logic        b_en;
        logic [31:0] b_addr;
        logic [31:0] b_data;
        logic [3:0]  b_wb;
        logic        chk_a;
        logic [31:0] exp_a;
        logic        chk_b;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name,
                       input logic a_en, input logic [31:0] a_addr, input logic [31:0] a_data,
                       input logic [3:0] a_wb,
                       input logic b_en, input logic [31:0] b_addr, input logic [31:0] b_data,
                       input logic [3:0] b_wb,
                       input logic chk_a, input logic [31:0] exp_a,
                       input logic chk_b, input logic [31:0] exp_b);
        vec_t v;
        v.name = name;
        v.a_en = a_en; v.a_addr = a_addr; v.a_data = a_data; v.a_wb = a_wb;
        v.b_en = b_en; v.b_addr = b_addr; v.b_data = b_data; v.b_wb = b_wb;
        v.chk_a = chk_a; v.exp_a = exp_a; v.chk_b = chk_b; v.exp_b = exp_b;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------ driver
    task automatic drive(input vec_t v);
        bus.a_enable_in = v.a_en;
        bus.a_addr_in   = v.a_addr;
        bus.a_data_in   = v.a_data;
        bus.a_wb_in     = v.a_wb;
        bus.b_enable_in = v.b_en;
        bus.b_addr_in   = v.b_addr;
        bus.b_data_in   = v.b_data;
        bus.b_wb_in     = v.b_wb;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        drive(v);
        @(posedge clock);
        #1;
        if (v.chk_a) check({v.name, " a_data_out"}, bus.a_data_out, v.exp_a);
        if (v.chk_b) check({v.name, " b_data_out"}, bus.b_data_out, v.exp_b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ test
    initial begin
        vec_t idle;
        vec_t v;

        //   name             aen a_addr        a_data        awb     ben b_addr        b_data        bwb     ca exp_a         cb exp_b
        add("b_wr_deadbeef",  0, 32'h0,        32'h0,        4'h0,   1, 32'h40000010, 32'hDEADBEEF, 4'hF,   0, 32'h0,        1, 32'h0);
        add("b_rd_deadbeef",  0, 32'h0,        32'h0,        4'h0,   1, 32'h40000010, 32'h0,        4'h0,   0, 32'h0,        1, 32'hDEADBEEF);
        add("a_wr_full",      1, 32'h20,       32'h11223344, 4'hF,   0, 32'h0,        32'h0,        4'h0,   1, 32'h0,        0, 32'h0);
        add("a_wr_lanes",     1, 32'h22,       32'hAABBCCDD, 4'h5,   0, 32'h0,        32'h0,        4'h0,   1, 32'h11223344, 0, 32'h0);
        add("b_rd_lanes",     0, 32'h0,        32'h0,        4'h0,   1, 32'h20,       32'h0,        4'h0,   0, 32'h0,        1, 32'h11BB33DD);
        add("b_wr_wrap",      0, 32'h0,        32'h0,        4'h0,   1, 32'h00010004, 32'hCAFEF00D, 4'hF,   0, 32'h0,        1, 32'h0);
        add("rd_wrap",        1, 32'h4,        32'h0,        4'h0,   1, 32'h13,       32'h0,        4'h0,   1, 32'hCAFEF00D, 1, 32'hDEADBEEF);
        add("coll_ww",        1, 32'h100,      32'h000000AA, 4'h1,   1, 32'h100,      32'h12345678, 4'hF,   1, 32'h0,        1, 32'h0);
        add("coll_ww_rd",     1, 32'h100,      32'h0,        4'h0,   1, 32'h102,      32'h0,        4'h0,   1, 32'h123456AA, 1, 32'h123456AA);
        add("clear_100",      1, 32'h100,      32'h0,        4'hF,   0, 32'h0,        32'h0,        4'h0,   1, 32'h123456AA, 0, 32'h0);
        add("coll_wr",        1, 32'h100,      32'h55,       4'hF,   1, 32'h100,      32'h0,        4'h0,   1, 32'h0,        1, 32'h0);
        add("coll_wr_next",   0, 32'h0,        32'h0,        4'h0,   1, 32'h100,      32'h0,        4'h0,   1, 32'h0,        1, 32'h55);
        add("a_wr_one",       1, 32'h0,        32'h1,        4'hF,   0, 32'h0,        32'h0,        4'h0,   1, 32'h0,        0, 32'h0);
        add("b_rd_one",       0, 32'h0,        32'h0,        4'h0,   1, 32'h0,        32'h0,        4'h0,   0, 32'h0,        1, 32'h1);
        add("hold_1",         1, 32'h0,        32'h2,        4'hF,   0, 32'h0,        32'hFFFFFFFF, 4'hF,   1, 32'h1,        1, 32'h1);
        add("hold_2",         1, 32'h0,        32'h2,        4'hF,   0, 32'h0,        32'hFFFFFFFF, 4'hF,   1, 32'h2,        1, 32'h1);
        add("hold_3",         1, 32'h0,        32'h2,        4'hF,   0, 32'h0,        32'hFFFFFFFF, 4'hF,   1, 32'h2,        1, 32'h1);
        add("b_rfirst",       0, 32'h0,        32'h0,        4'hF,   1, 32'h0,        32'h3,        4'hF,   1, 32'h2,        1, 32'h2);
        add("a_rd_three",     1, 32'h0,        32'h0,        4'h0,   0, 32'h0,        32'h0,        4'h0,   1, 32'h3,        1, 32'h2);
        add("a_wr_top",       1, 32'hFFFFFFFC, 32'h0BADCAFE, 4'hF,   0, 32'h0,        32'h0,        4'h0,   1, 32'h0,        0, 32'h0);
        add("rd_top",         1, 32'h10,       32'h0,        4'h0,   1, 32'h0000FFFC, 32'h0,        4'h0,   1, 32'hDEADBEEF, 1, 32'h0BADCAFE);
        add("coll_split",     1, 32'h200,      32'hAABB1111, 4'hC,   1, 32'h200,      32'h2222CCDD, 4'h3,   1, 32'h0,        1, 32'h0);
        add("coll_split_rd",  1, 32'h201,      32'h0,        4'h0,   1, 32'h200,      32'h0,        4'h0,   1, 32'hAABBCCDD, 1, 32'hAABBCCDD);

        idle = '{name: "idle", a_en: 0, a_addr: 0, a_data: 0, a_wb: 0,
                 b_en: 0, b_addr: 0, b_data: 0, b_wb: 0,
                 chk_a: 0, exp_a: 0, chk_b: 0, exp_b: 0};

        // Reset holds outputs at zero even with reads enabled.
        v = idle;
        v.a_en = 1; v.a_addr = 32'h10;
        v.b_en = 1; v.b_addr = 32'h10;
        drive(v);
        repeat (2) @(posedge clock);
        #1;
        check("reset a_data_out", bus.a_data_out, 32'h0);
        check("reset b_data_out", bus.b_data_out, 32'h0);
        @(negedge clock);
        drive(idle);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset in the middle of a burst.
        v = idle;
        v.name = "rst_wr"; v.a_en = 1; v.a_addr = 32'h300; v.a_data = 32'h5A5A5A5A; v.a_wb = 4'hF;
        apply(v);
        v = idle;
        v.name = "rst_pre"; v.a_en = 1; v.a_addr = 32'h300; v.chk_a = 1; v.exp_a = 32'h5A5A5A5A;
        apply(v);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async a_data_out", bus.a_data_out, 32'h0);
        check("rst_async b_data_out", bus.b_data_out, 32'h0);

        // A write on an edge while reset is held must still land.
        @(negedge clock);
        v = idle;
        v.a_en = 1; v.a_addr = 32'h304; v.a_data = 32'h77; v.a_wb = 4'hF;
        v.b_en = 1; v.b_addr = 32'h300;
        drive(v);
        @(posedge clock);
        #1;
        check("rst_held a_data_out", bus.a_data_out, 32'h0);
        check("rst_held b_data_out", bus.b_data_out, 32'h0);

        @(negedge clock);
        drive(idle);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_idle a_data_out", bus.a_data_out, 32'h0);

        v = idle;
        v.name = "rst_readback"; v.a_en = 1; v.a_addr = 32'h300; v.b_en = 1; v.b_addr = 32'h304;
        v.chk_a = 1; v.exp_a = 32'h5A5A5A5A; v.chk_b = 1; v.exp_b = 32'h77;
        apply(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
